run_monitor: RTL and testbench

RUN_MONITOR -- requirements
Module: run_monitor

---
 rtl/run_monitor_pkg.sv | 32 +++
 rtl/run_monitor_trace_fifo.sv | 72 +++++++
 rtl/run_monitor.sv | 175 +++++++++++++++++
 tb/tb_run_monitor.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/run_monitor_pkg.sv
// Purpose: shared types and constants for the run_monitor block (FSM states, halt codes, trace entry).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package run_monitor_pkg;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_RESET_CORE = 2'd1,
    ST_RUN        = 2'd2,
    ST_DONE       = 2'd3
  } state_t;

  // halt_reason encoding.
  localparam logic [1:0] HALT_NONE    = 2'd0;
  localparam logic [1:0] HALT_STALL   = 2'd1;
  localparam logic [1:0] HALT_TIMEOUT = 2'd2;

  // One writeback as stored in the trace FIFO: register index in the top bits, data below.
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] dat;
  } trace_t;

  localparam int TRACE_W = $bits(trace_t);

  // Saturating 32-bit increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/run_monitor_trace_fifo.sv
// Purpose: generic synchronous FIFO used for the writeback trace (module trace_fifo).
// Latency: a push is visible at the head one cycle later; the head advances the cycle after a pop.
// Backpressure: none upstream -- a push into a full FIFO without a same-cycle pop is dropped and flagged on drop.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   clear           synchronous flush (empties the FIFO, contents ignored)
//   push_vld/dat    write request and data
//   pop_vld         read request (ignored while empty)
//   head_vld/dat    FIFO non-empty and the oldest entry
//   count           entries held (0..DEPTH)
//   full            count == DEPTH
//   drop            this cycle's push is being discarded
module trace_fifo #(
  parameter int WIDTH = 37,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push_vld,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop_vld,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     drop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == FULL_CNT);
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];

  // A pop frees a slot in the same cycle, so a full FIFO still accepts a push
  // when it is being read at the same time.
  assign do_pop  = pop_vld && head_vld;
  assign do_push = push_vld && (!full || do_pop);
  assign drop    = push_vld && full && !do_pop;

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; head_vld qualifies head_dat.
  always_ff @(posedge clk) begin
    if (do_push && !reset && !clear) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/run_monitor.sv
// Purpose: supervises one core run -- holds the core in reset, runs it, detects pc stall or timeout, traces writebacks.
// Latency: FSM outputs are decoded from registered state; halt/timeout are detected in the cycle they occur and DONE follows on the next edge.
// Backpressure: none on the core side; trace writebacks beyond TRACE_DEPTH are dropped and latched in trace_overflow.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   start                 one-cycle pulse, accepted only in IDLE or DONE
//   pc                    core program counter (stall detection)
//   reg_write/wb_reg/wb_data  core writeback, traced while running
//   trace_rd              pop the trace head (any state)
//   core_reset            reset to the core (IDLE, RESET_CORE)
//   running, done         RUN / DONE state flags
//   halt_reason           0 none, 1 pc stall, 2 timeout
//   cycle_count           RUN cycles elapsed (saturating)
//   trace_valid/reg/data  trace head
//   trace_count           trace entries held
//   trace_overflow        sticky: a writeback was dropped
module run_monitor
  import run_monitor_pkg::*;
#(
  parameter int RESET_CYCLES = 1,
  parameter int MAX_CYCLES   = 100,
  parameter int HALT_REPEAT  = 3,   // expected >= 2
  parameter int TRACE_DEPTH  = 16   // power of two, >= 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [31:0]                    pc,
  input  logic                           reg_write,
  input  logic [4:0]                     wb_reg,
  input  logic [31:0]                    wb_data,
  input  logic                           trace_rd,
  output logic                           core_reset,
  output logic                           running,
  output logic                           done,
  output logic [1:0]                     halt_reason,
  output logic [31:0]                    cycle_count,
  output logic                           trace_valid,
  output logic [4:0]                     trace_reg,
  output logic [31:0]                    trace_data,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic                           trace_overflow
);

  localparam int RCW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RC_LAST   = RCW'(RESET_CYCLES - 1);
  localparam logic [31:0]    STALL_LIM = 32'(HALT_REPEAT - 1);
  localparam logic [31:0]    TIME_LIM  = 32'(MAX_CYCLES - 1);

  state_t         state;
  state_t         state_nxt;
  logic [RCW-1:0] rc_cnt;
  logic [31:0]    stall_cnt;
  logic [31:0]    stall_nxt;
  logic [31:0]    prev_pc;
  logic           have_prev;
  logic           in_run;
  logic           enter_rc;
  logic           rc_last;
  logic           pc_same;
  logic           halt_hit;
  logic           timeout_hit;
  logic           wb_push;
  logic           fifo_drop;
  logic           fifo_full;
  trace_t         wb_entry;
  trace_t         head_entry;

  assign in_run   = (state == ST_RUN);
  assign enter_rc = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign rc_last  = (rc_cnt == RC_LAST);

  // have_prev is low in the first RUN cycle, so that cycle always counts as a
  // pc change even if the pc left over from before the run happens to match.
  assign pc_same     = in_run && have_prev && (pc == prev_pc);
  assign stall_nxt   = pc_same ? stall_cnt + 32'd1 : 32'd0;
  // HALT_REPEAT consecutive cycles at the same pc means HALT_REPEAT-1 repeats.
  assign halt_hit    = pc_same && (stall_nxt == STALL_LIM);
  assign timeout_hit = in_run && (cycle_count == TIME_LIM);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    core_reset = 1'b0;
    running    = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        core_reset = 1'b1;
        if (start) state_nxt = ST_RESET_CORE;
      end
      ST_RESET_CORE: begin
        core_reset = 1'b1;
        if (rc_last) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        running = 1'b1;
        if (halt_hit || timeout_hit) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) state_nxt = ST_RESET_CORE;
      end
      default: begin
        core_reset = 1'b1;
        state_nxt  = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------- run bookkeeping
  always_ff @(posedge clk) begin
    if (reset) begin
      rc_cnt         <= '0;
      stall_cnt      <= '0;
      prev_pc        <= '0;
      have_prev      <= 1'b0;
      cycle_count    <= '0;
      halt_reason    <= HALT_NONE;
      trace_overflow <= 1'b0;
    end else begin
      prev_pc   <= pc;
      have_prev <= in_run;
      if (enter_rc) begin
        rc_cnt         <= '0;
        stall_cnt      <= '0;
        cycle_count    <= '0;
        halt_reason    <= HALT_NONE;
        trace_overflow <= 1'b0;
      end else begin
        if ((state == ST_RESET_CORE) && !rc_last) rc_cnt <= rc_cnt + RCW'(1);
        if (in_run) begin
          stall_cnt   <= stall_nxt;
          cycle_count <= sat_inc32(cycle_count);
          // Stall wins when both fire in the same cycle.
          if (halt_hit)         halt_reason <= HALT_STALL;
          else if (timeout_hit) halt_reason <= HALT_TIMEOUT;
        end
        if (fifo_drop) trace_overflow <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------- writeback trace
  assign wb_push      = reg_write && in_run;
  assign wb_entry.rd  = wb_reg;
  assign wb_entry.dat = wb_data;

  trace_fifo #(
    .WIDTH (TRACE_W),
    .DEPTH (TRACE_DEPTH)
  ) u_trace_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (enter_rc),
    .push_vld (wb_push),
    .push_dat (wb_entry),
    .pop_vld  (trace_rd),
    .head_vld (trace_valid),
    .head_dat (head_entry),
    .count    (trace_count),
    .full     (fifo_full),
    .drop     (fifo_drop)
  );

  assign trace_reg  = head_entry.rd;
  assign trace_data = head_entry.dat;

endmodule

// File: tb/tb_run_monitor.sv
// Purpose: self-checking bench for run_monitor (vector table + scoreboard of trace entries).
// Latency: inputs change 1 time unit after the rising edge; outputs are checked at the same point.
// Backpressure: n/a.
module tb_run_monitor;

  localparam int RC = 2;
  localparam int MC = 100;
  localparam int HR = 3;
  localparam int TD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] pc;
  logic        reg_write;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        trace_rd;
  logic        core_reset;
  logic        running;
  logic        done;
  logic [1:0]  halt_reason;
  logic [31:0] cycle_count;
  logic        trace_valid;
  logic [4:0]  trace_reg;
  logic [31:0] trace_data;
  logic [2:0]  trace_count;
  logic        trace_overflow;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } sb_t;
  sb_t  sb[$];
  logic model_ovf;

  typedef struct {
    logic [31:0] pc;
    logic        wr;
    logic [4:0]  r;
    logic [31:0] d;
    logic        rd;
    logic        e_run;
    logic        e_done;
    logic [1:0]  e_halt;
    logic [31:0] e_cyc;
  } vec_t;
  vec_t vt[7];

  run_monitor #(
    .RESET_CYCLES (RC),
    .MAX_CYCLES   (MC),
    .HALT_REPEAT  (HR),
    .TRACE_DEPTH  (TD)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .pc             (pc),
    .reg_write      (reg_write),
    .wb_reg         (wb_reg),
    .wb_data        (wb_data),
    .trace_rd       (trace_rd),
    .core_reset     (core_reset),
    .running        (running),
    .done           (done),
    .halt_reason    (halt_reason),
    .cycle_count    (cycle_count),
    .trace_valid    (trace_valid),
    .trace_reg      (trace_reg),
    .trace_data     (trace_data),
    .trace_count    (trace_count),
    .trace_overflow (trace_overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One clock with the given inputs; the scoreboard checks the head on a pop
  // and records the expected effect of a writeback.
  task automatic cycle(input logic [31:0] p, input logic w, input logic [4:0] r,
                       input logic [31:0] d, input logic rd, input logic model_run);
    pc = p; reg_write = w; wb_reg = r; wb_data = d; trace_rd = rd;
    if (rd && sb.size() > 0) begin
      chk("trace_head_valid", 32'(trace_valid), 32'd1);
      chk("trace_head_reg", 32'(trace_reg), 32'(sb[0].r));
      chk("trace_head_data", trace_data, sb[0].d);
      void'(sb.pop_front());
    end
    if (w && model_run) begin
      if (sb.size() < TD) sb.push_back('{r, d});
      else model_ovf = 1'b1;
    end
    tick;
    reg_write = 1'b0; trace_rd = 1'b0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_count"}, 32'(trace_count), sb.size());
    chk({tag, "_ovf"}, 32'(trace_overflow), 32'(model_ovf));
  endtask

  // start pulse then RESET_CORE for exactly RC cycles, then RUN with cleared state.
  task automatic do_start;
    sb.delete();
    model_ovf = 1'b0;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("rc1_core_reset", 32'(core_reset), 32'd1);
    chk("rc1_running", 32'(running), 32'd0);
    tick;
    chk("rc2_core_reset", 32'(core_reset), 32'd1);
    chk("rc2_running", 32'(running), 32'd0);
    tick;
    chk("run_entry_running", 32'(running), 32'd1);
    chk("run_entry_core_reset", 32'(core_reset), 32'd0);
    chk("run_entry_cycles", cycle_count, 32'd0);
    chk("run_entry_halt", 32'(halt_reason), 32'd0);
    check_model("run_entry");
  endtask

  task automatic drain(input logic [31:0] p);
    int guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      cycle(p, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
      guard++;
      chk("drain_count", 32'(trace_count), sb.size());
    end
    chk("drain_empty_valid", 32'(trace_valid), 32'd0);
    // Pop while empty is ignored.
    cycle(p, 1'b0, 5'd0, 32'd0, 1'b1, 1'b0);
    chk("empty_pop_count", 32'(trace_count), 32'd0);
    chk("empty_pop_valid", 32'(trace_valid), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_halt"}, 32'(halt_reason), 32'd0);
    chk({tag, "_cycles"}, cycle_count, 32'd0);
    chk({tag, "_valid"}, 32'(trace_valid), 32'd0);
    chk({tag, "_count"}, 32'(trace_count), 32'd0);
    chk({tag, "_ovf"}, 32'(trace_overflow), 32'd0);
  endtask

  initial begin
    logic [31:0] p;
    int n;
    logic mrun;

    // Stall halt with trace overflow: pc 0,4,8,12,12,12 then a DONE-state writeback.
    //           pc     wr    r     d        rd    run   done  halt  cycles
    vt[0] = '{32'd0,  1'b1, 5'd1, 32'h10, 1'b0, 1'b1, 1'b0, 2'd0, 32'd1};
    vt[1] = '{32'd4,  1'b1, 5'd2, 32'h20, 1'b0, 1'b1, 1'b0, 2'd0, 32'd2};
    vt[2] = '{32'd8,  1'b1, 5'd3, 32'h30, 1'b0, 1'b1, 1'b0, 2'd0, 32'd3};
    vt[3] = '{32'd12, 1'b1, 5'd4, 32'h40, 1'b0, 1'b1, 1'b0, 2'd0, 32'd4};
    vt[4] = '{32'd12, 1'b1, 5'd5, 32'h50, 1'b0, 1'b1, 1'b0, 2'd0, 32'd5};
    vt[5] = '{32'd12, 1'b0, 5'd0, 32'h00, 1'b0, 1'b0, 1'b1, 2'd1, 32'd6};
    vt[6] = '{32'd12, 1'b1, 5'd9, 32'h90, 1'b0, 1'b0, 1'b1, 2'd1, 32'd6};

    reset = 1'b1; start = 1'b0; pc = 32'd0; reg_write = 1'b0;
    wb_reg = 5'd0; wb_data = 32'd0; trace_rd = 1'b0;
    sb.delete(); model_ovf = 1'b0;
    tick; tick;
    reset = 1'b0;
    check_reset_values("reset");
    tick;
    check_reset_values("idle");

    // ---- run 1: table-driven stall halt and overflow
    do_start;
    mrun = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cycle(vt[i].pc, vt[i].wr, vt[i].r, vt[i].d, vt[i].rd, mrun);
      chk("vec_running", 32'(running), 32'(vt[i].e_run));
      chk("vec_done", 32'(done), 32'(vt[i].e_done));
      chk("vec_halt", 32'(halt_reason), 32'(vt[i].e_halt));
      chk("vec_cycles", cycle_count, vt[i].e_cyc);
      chk("vec_core_reset", 32'(core_reset), 32'd0);
      check_model("vec");
      mrun = vt[i].e_run;
    end
    drain(32'd12);

    // ---- run 2: full FIFO push+pop, ignored start, timeout
    do_start;
    p = 32'd1000;
    n = 0;
    for (int i = 0; i < 4; i++) begin
      cycle(p, 1'b1, 5'(i + 1), 32'((i + 1) * 16), 1'b0, 1'b1);
      p += 4; n++;
    end
    check_model("fill");
    cycle(p, 1'b1, 5'd5, 32'h50, 1'b1, 1'b1);
    p += 4; n++;
    chk("pushpop_count", 32'(trace_count), 32'd4);
    chk("pushpop_ovf", 32'(trace_overflow), 32'd0);
    start = 1'b1;
    cycle(p, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    start = 1'b0;
    p += 4; n++;
    chk("start_in_run_running", 32'(running), 32'd1);
    chk("start_in_run_cycles", cycle_count, 32'(n));
    while (!done && n < 200) begin
      cycle(p, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      p += 4; n++;
    end
    chk("timeout_done", 32'(done), 32'd1);
    chk("timeout_halt", 32'(halt_reason), 32'd2);
    chk("timeout_cycles", cycle_count, 32'd100);
    chk("timeout_edges", 32'(n), 32'd100);
    cycle(p, 1'b0, 5'd0, 32'd0, 1'b0, 1'b0);
    chk("done_hold_cycles", cycle_count, 32'd100);
    chk("done_hold_done", 32'(done), 32'd1);
    drain(p);

    // ---- run 3: reset mid-run, then a clean run that stalls from its first cycle
    do_start;
    p = 32'd500;
    for (int i = 0; i < 10; i++) begin
      cycle(p, 1'b1, 5'(i + 1), 32'(i), 1'b0, 1'b1);
      p += 4;
    end
    chk("pre_abort_running", 32'(running), 32'd1);
    check_model("pre_abort");
    reset = 1'b1;
    pc = 32'd100;
    tick;
    reset = 1'b0;
    sb.delete(); model_ovf = 1'b0;
    check_reset_values("abort");
    do_start;
    cycle(32'd100, 1'b1, 5'd7, 32'h77, 1'b0, 1'b1);
    chk("stall_c0_running", 32'(running), 32'd1);
    cycle(32'd100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("stall_c1_running", 32'(running), 32'd1);
    cycle(32'd100, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_halt", 32'(halt_reason), 32'd1);
    chk("stall_cycles", cycle_count, 32'd3);
    check_model("stall");
    drain(32'd100);

    // ---- run 4: stall and timeout in the same cycle -> stall reported
    do_start;
    for (int c = 0; c < 100; c++) begin
      p = (c <= 97) ? 32'(2000 + 4 * c) : 32'(2000 + 4 * 97);
      cycle(p, 1'b0, 5'd0, 32'd0, 1'b0, 1'b1);
      if (c == 98) chk("prio_c98_running", 32'(running), 32'd1);
    end
    chk("prio_done", 32'(done), 32'd1);
    chk("prio_halt", 32'(halt_reason), 32'd1);
    chk("prio_cycles", cycle_count, 32'd100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
